// File: rtl/alu_seq_pkg.sv
// Shared opcodes and sequencer state encoding for the ALU sequencer.
// Imported by alu_step_counter and alu_seq_ctrl.
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXEC,
        CHECK,
        DONE
    } seq_state_t;

endpackage

// File: rtl/alu_step_counter.sv
// Iteration counter for the MUL/DIV loops; wraps after its top value.
// last flags the final iteration so the sequencer can exit the loop.
module alu_step_counter
    import alu_seq_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             count_up,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear has priority over advancing
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_up) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == {CNT_W{1'b1}});

endmodule

// File: rtl/alu_seq_ctrl.sv
// Control sequencer for the iterative ALU datapath (ADD, MUL, DIV).
// Optional abort port pair enabled by defining ALU_SEQ_ABORT_EN.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             mul_lsb,
    input  logic             acc_msb,
`ifdef ALU_SEQ_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             ld_operands,
    output logic             add_en,
    output logic             sub_en,
    output logic             restore_en,
    output logic             shift_en,
    output logic             q_wr,
    output logic             q_bit,
    output logic             count_up,
    output logic [CNT_W-1:0] step,
    output logic             busy,
    output logic             done,
    output logic             err
);

    seq_state_t state_q;
    seq_state_t state_d;
    logic [1:0] op_q;
    logic [1:0] op_d;
    logic       aborted_q;
    logic       aborted_d;
    logic       cnt_clear;
    logic       cnt_last;

    alu_step_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .count_up(count_up),
        .count   (step),
        .last    (cnt_last)
    );

    // Next-state and control decode from the registered state
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        aborted_d   = 1'b0;
        cnt_clear   = 1'b0;
        ld_operands = 1'b0;
        add_en      = 1'b0;
        sub_en      = 1'b0;
        restore_en  = 1'b0;
        shift_en    = 1'b0;
        q_wr        = 1'b0;
        q_bit       = 1'b0;
        count_up    = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    op_d    = op;
                end
            end
            LOAD: begin
                ld_operands = 1'b1;
                cnt_clear   = 1'b1;
                state_d     = (op_q == OP_ILL) ? DONE : EXEC;
            end
            EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        add_en  = 1'b1;
                        state_d = DONE;
                    end
                    OP_MUL: begin
                        add_en   = mul_lsb;
                        shift_en = 1'b1;
                        count_up = 1'b1;
                        state_d  = cnt_last ? DONE : EXEC;
                    end
                    OP_DIV: begin
                        shift_en = 1'b1;
                        sub_en   = 1'b1;
                        state_d  = CHECK;
                    end
                    default: state_d = DONE;
                endcase
            end
            CHECK: begin
                q_wr       = 1'b1;
                q_bit      = ~acc_msb;
                restore_en = acc_msb;
                count_up   = 1'b1;
                state_d    = cnt_last ? DONE : EXEC;
            end
            DONE: begin
                done    = 1'b1;
                err     = (op_q == OP_ILL);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef ALU_SEQ_ABORT_EN
        if (abort && (state_q == LOAD || state_q == EXEC
                      || state_q == CHECK)) begin
            state_d     = IDLE;
            aborted_d   = 1'b1;
            cnt_clear   = 1'b0;
            ld_operands = 1'b0;
            add_en      = 1'b0;
            sub_en      = 1'b0;
            restore_en  = 1'b0;
            shift_en    = 1'b0;
            q_wr        = 1'b0;
            q_bit       = 1'b0;
            count_up    = 1'b0;
        end
`endif
    end

    // Sequencer state, latched opcode and abort flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= OP_ADD;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            aborted_q <= aborted_d;
        end
    end

    assign busy = (state_q != IDLE);

`ifdef ALU_SEQ_ABORT_EN
    assign aborted = aborted_q;
`else
    logic unused_aborted;
    assign unused_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl (WIDTH=8).
// Abort scenario is built only when ALU_SEQ_ABORT_EN is defined.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic             mul_lsb;
    logic             acc_msb;
    logic             ld_operands;
    logic             add_en;
    logic             sub_en;
    logic             restore_en;
    logic             shift_en;
    logic             q_wr;
    logic             q_bit;
    logic             count_up;
    logic [CNT_W-1:0] step;
    logic             busy;
    logic             done;
    logic             err;
`ifdef ALU_SEQ_ABORT_EN
    logic             abort;
    logic             aborted;
`endif

    alu_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .mul_lsb    (mul_lsb),
        .acc_msb    (acc_msb),
`ifdef ALU_SEQ_ABORT_EN
        .abort      (abort),
        .aborted    (aborted),
`endif
        .ld_operands(ld_operands),
        .add_en     (add_en),
        .sub_en     (sub_en),
        .restore_en (restore_en),
        .shift_en   (shift_en),
        .q_wr       (q_wr),
        .q_bit      (q_bit),
        .count_up   (count_up),
        .step       (step),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] lsb;
        logic [7:0] msb;
        int         lat;
        logic       err;
        int         n_add;
        int         n_sub;
        int         n_rst;
        int         n_sh;
        int         n_qwr;
        int         n_cnt;
        logic [7:0] qv;
    } vec_t;

    typedef struct {
        int         lat;
        logic       err;
        int         n_add;
        int         n_sub;
        int         n_rst;
        int         n_sh;
        int         n_qwr;
        int         n_cnt;
        int         n_ld;
        int         n_busy;
        int         n_done;
        int         n_bad;
        int         step_bad;
        logic [7:0] addv;
        logic [7:0] qv;
    } res_t;

    function automatic logic [15:0] all_out();
        return {ld_operands, add_en, sub_en, restore_en, shift_en,
                q_wr, q_bit, count_up, busy, done, err, step, 2'b00};
    endfunction

    // Issue one command and watch it until done (or a 100-cycle bound).
    task automatic run_op(input logic [1:0] o, input logic [7:0] lsb,
                          input logic [7:0] msb, input logic hold,
                          output res_t r);
        int c;
        int shi;
        int qi;
        r = '{lat: -1, err: 1'b0, addv: 8'h00, qv: 8'h00, default: 0};
        shi = 0;
        qi  = 0;
        @(posedge clk); #1;
        start   = 1'b1;
        op      = o;
        mul_lsb = 1'b0;
        acc_msb = 1'b0;
        @(posedge clk); #1;
        start = hold;
        op    = ~o;
        for (c = 1; c <= 100; c++) begin
            mul_lsb = (c >= 2 && c - 2 < 8) ? lsb[c-2] : 1'b0;
            acc_msb = (c >= 3 && (c - 3) / 2 < 8) ? msb[(c-3)/2] : 1'b0;
            @(negedge clk);
            if (ld_operands) r.n_ld++;
            if (add_en) r.n_add++;
            if (sub_en) r.n_sub++;
            if (restore_en) r.n_rst++;
            if (count_up) r.n_cnt++;
            if (busy) r.n_busy++;
            if ((add_en & sub_en) | (add_en & restore_en)
                | (sub_en & restore_en) | (shift_en & restore_en))
                r.n_bad++;
            if (err & ~done) r.n_bad++;
            if (shift_en) begin
                if (shi < 8) r.addv[shi] = add_en;
                if (32'(step) != shi) r.step_bad++;
                shi++;
                r.n_sh++;
            end
            if (q_wr) begin
                if (qi < 8) r.qv[qi] = q_bit;
                qi++;
                r.n_qwr++;
            end
            if (done) begin
                r.n_done++;
                r.lat = c - 1;
                r.err = err;
                start = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    vec_t vecs[6];
    res_t r;
    int   nd;
    int   found;

    initial begin
        vecs[0] = '{OP_ADD, 8'h00, 8'h00, 2, 1'b0, 1, 0, 0, 0, 0, 0, 8'h00};
        vecs[1] = '{OP_MUL, 8'hFF, 8'h00, 9, 1'b0, 8, 0, 0, 8, 0, 8, 8'h00};
        vecs[2] = '{OP_MUL, 8'h00, 8'h00, 9, 1'b0, 0, 0, 0, 8, 0, 8, 8'h00};
        vecs[3] = '{OP_DIV, 8'h00, 8'h00, 17, 1'b0, 0, 8, 0, 8, 8, 8, 8'hFF};
        vecs[4] = '{OP_DIV, 8'h00, 8'hFF, 17, 1'b0, 0, 8, 8, 8, 8, 8, 8'h00};
        vecs[5] = '{OP_ILL, 8'h00, 8'h00, 1, 1'b1, 0, 0, 0, 0, 0, 0, 8'h00};

        reset   = 1'b1;
        start   = 1'b0;
        op      = OP_ADD;
        mul_lsb = 1'b0;
        acc_msb = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
        abort   = 1'b0;
`endif
        #1;
        check("reset_outputs", 32'(all_out()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 32'(all_out()), 32'd0);

        // Table: consecutive runs also exercise back-to-back starts
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].op, vecs[i].lsb, vecs[i].msb, 1'b0, r);
            check($sformatf("v%0d_lat", i), r.lat, vecs[i].lat);
            check($sformatf("v%0d_err", i), 32'(r.err), 32'(vecs[i].err));
            check($sformatf("v%0d_add", i), r.n_add, vecs[i].n_add);
            check($sformatf("v%0d_sub", i), r.n_sub, vecs[i].n_sub);
            check($sformatf("v%0d_rst", i), r.n_rst, vecs[i].n_rst);
            check($sformatf("v%0d_shift", i), r.n_sh, vecs[i].n_sh);
            check($sformatf("v%0d_qwr", i), r.n_qwr, vecs[i].n_qwr);
            check($sformatf("v%0d_cnt", i), r.n_cnt, vecs[i].n_cnt);
            check($sformatf("v%0d_qv", i), 32'(r.qv), 32'(vecs[i].qv));
            check($sformatf("v%0d_ld", i), r.n_ld, 1);
            check($sformatf("v%0d_busy", i), r.n_busy, vecs[i].lat + 1);
            check($sformatf("v%0d_excl", i), r.n_bad, 0);
        end

        // MUL with multiplier bits 1,0,1,1,0,0,1,0
        run_op(OP_MUL, 8'h4D, 8'h00, 1'b0, r);
        check("mul_pat_lat", r.lat, 9);
        check("mul_pat_add", 32'(r.addv), 32'h4D);
        check("mul_pat_step", r.step_bad, 0);
        check("mul_pat_shift", r.n_sh, 8);

        // DIV with sign alternating 0,1 on each CHECK
        run_op(OP_DIV, 8'h00, 8'hAA, 1'b0, r);
        check("div_alt_lat", r.lat, 17);
        check("div_alt_q", 32'(r.qv), 32'h55);
        check("div_alt_rst", r.n_rst, 4);
        check("div_alt_step", r.step_bad, 0);

        // start held high throughout a MUL: one done, no restart
        run_op(OP_MUL, 8'h00, 8'h00, 1'b1, r);
        check("mul_hold_lat", r.lat, 9);
        check("mul_hold_done", r.n_done, 1);
        nd = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy | done) nd++;
        end
        check("mul_hold_norestart", nd, 0);

        // Reset asserted at DIV step 3
        @(posedge clk); #1;
        start = 1'b1;
        op    = OP_DIV;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sub_en && step == 3'd3) begin
                found = 1;
                break;
            end
        end
        check("div_step3_reached", found, 1);
        #1;
        reset = 1'b1;
        #1;
        check("mid_reset_outputs", 32'(all_out()), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_op(OP_MUL, 8'h00, 8'h00, 1'b0, r);
        check("post_reset_mul_lat", r.lat, 9);
        check("post_reset_mul_done", r.n_done, 1);

`ifdef ALU_SEQ_ABORT_EN
        // Abort MUL at step 4
        @(posedge clk); #1;
        start = 1'b1;
        op    = OP_MUL;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        nd    = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (shift_en && step == 3'd4) begin
                found = 1;
                break;
            end
        end
        check("abort_step4_reached", found, 1);
        abort   = 1'b1;
        mul_lsb = 1'b1;
        #1;
        check("abort_enables", 32'({add_en, sub_en, restore_en,
                                    shift_en, count_up, q_wr}), 32'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_pulse", 32'(aborted), 32'd1);
        if (done) nd++;
        @(negedge clk);
        check("abort_pulse_end", 32'(aborted), 32'd0);
        if (done) nd++;
        check("abort_no_done", nd, 0);
        mul_lsb = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
